data_sram_like_bridge: RTL and testbench
========================================

Name: data_sram_like_bridge

Overview:
- Sits directly downstream of the CPU core's memory (M) stage data port and converts it to the SoC's sram-like handshake bus (req / addr_ok / data_ok).
- The core's M-stage access is single-cycle. This bridge turns it into a multi-cycle bus transaction and raises cpu_stall until the result is available.
- It holds the completed result while the rest of the pipeline is frozen, for example by a divider stall, so an access is never issued twice.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be 32.
- KSEG_MAP, 1, when 1 the bus address is the physical address from fixed kseg0/kseg1 unmapping; when 0 the CPU address passes through unchanged.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_en  in  1  M-stage memory access valid (load or store).
- cpu_wen  in  4  byte write enables; 0 means read.
- cpu_size  in  2  access size: 0 byte, 1 half, 2 word.
- cpu_addr  in  ADDR_W  virtual address (aluoutM).
- cpu_wdata  in  DATA_W  store data, already byte-lane aligned.
- cpu_flush  in  1  exception flush; suppresses the issue of a new access.
- cpu_longest_stall  in  1  pipeline frozen by another source (stall or div_stall).
- cpu_rdata  out  DATA_W  load data to the W-stage register.
- cpu_stall  out  1  freeze the pipeline.
- data_req  out  1  bus request.
- data_wr  out  1  1 for write.
- data_size  out  2  equal to cpu_size.
- data_addr  out  ADDR_W  physical address.
- data_wdata  out  DATA_W  write data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  transaction complete; read data valid.
- data_rdata  in  DATA_W  read data.

Behaviour:
- Reset values: state=IDLE, rdata_q=0, cpu_stall=0, data_req=0. data_wr, data_addr and data_wdata are 0 in IDLE when cpu_en=0.
- Address map with KSEG_MAP=1:
  - addr[31:29] equal to 3'b100 or 3'b101 maps to {3'b000, addr[28:0]}.
  - All other addresses pass through unchanged.
- Request fields: data_wr = |cpu_wen. data_addr, data_wdata and data_size are driven combinationally from the cpu_* inputs in every state; the core keeps these inputs stable while stalled.
- IDLE:
  - data_req = cpu_en & ~cpu_flush.
  - addr_ok=1 and data_ok=1 in the same cycle: capture data_rdata and go to DONE.
  - addr_ok=1 alone: go to WAIT.
  - A request that is not accepted goes to REQ.
- REQ:
  - data_req=1.
  - addr_ok with data_ok goes to DONE (rdata captured).
  - addr_ok alone goes to WAIT.
- WAIT:
  - data_req=0.
  - data_ok: capture data_rdata into rdata_q and go to DONE.
  - data_ok before addr_ok is never expected; it is ignored in IDLE and REQ.
- DONE:
  - data_req=0 and cpu_stall=0.
  - If cpu_longest_stall=0, go to IDLE at this edge, because the pipeline advances at the same edge.
  - Otherwise stay in DONE and issue nothing.
- cpu_stall = cpu_en & (state != DONE), and is 0 whenever cpu_flush=1 in IDLE. The minimum stall is 1 cycle.
- cpu_rdata = rdata_q. It is held until the next data_ok and is valid for writes too (the stale value is don't-care).
- cpu_flush arriving while in REQ or WAIT: the bus transaction cannot be cancelled.
  - The bridge completes the handshake.
  - cpu_stall stays asserted until DONE; it then passes through DONE and returns to IDLE.
  - The core discards the result.
- Back-to-back accesses: from DONE→IDLE, the next cpu_en is issued in the following cycle, one idle bus cycle minimum.
- Reset asserted mid-transaction: the state returns to IDLE immediately. The SoC resets the bus slave together with the bridge.
- Only one outstanding transaction is ever allowed.

Optional Feature:
- Macro SRAM_LIKE_FASTPATH_EN.
- Defined:
  - In WAIT, or in REQ with addr_ok, a data_ok arriving with cpu_longest_stall=0 drops cpu_stall in that same cycle.
  - cpu_rdata = data_rdata combinationally in that cycle, and the state goes straight to IDLE.
  - The minimum stall becomes 0 extra cycles after data_ok.
- Undefined: the registered path described above; there is always a DONE cycle.

Test Plan:
- Read, slave addr_ok in cycle 0 and data_ok in cycle 2, data_rdata=32'hDEADBEEF, addr=32'hBFC0_1000 → data_addr=32'h1FC0_1000, data_wr=0, cpu_stall high for cycles 0-2, cpu_rdata=32'hDEADBEEF from cycle 3, state back to IDLE.
- Byte store, wen=4'b0100, size=0, addr_ok delayed 3 cycles → data_req held for 4 cycles, data_wr=1, data_size=0, exactly one addr_ok accepted.
- Read completes while cpu_longest_stall=1 for 5 cycles → bridge stays in DONE, no second data_req, cpu_rdata is stable; it returns to IDLE on the cycle longest_stall drops.
- cpu_flush=1 with cpu_en=1 in IDLE → data_req=0, cpu_stall=0. Flush raised during WAIT → stall held until data_ok, then DONE→IDLE, no new request.
- Same-cycle addr_ok and data_ok (zero-wait slave), 4 consecutive loads → each costs exactly 1 stall cycle plus 1 DONE cycle, and the captured data match per access.
- Reset asserted in WAIT → next cycle state=IDLE, cpu_stall=0, data_req=0, rdata_q=0.

Source files
------------

// File: rtl/data_sram_like_bridge.sv
// M-stage data port to sram-like (req/addr_ok/data_ok) bus bridge with stall and result hold.
// Optional SRAM_LIKE_FASTPATH_EN: forward data_ok straight to the core and skip the DONE cycle.
module data_sram_like_bridge #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned KSEG_MAP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en_i,
    input  logic [3:0]        cpu_wen_i,
    input  logic [1:0]        cpu_size_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    input  logic              cpu_flush_i,
    input  logic              cpu_longest_stall_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              data_req_o,
    output logic              data_wr_o,
    output logic [1:0]        data_size_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [DATA_W-1:0] data_wdata_o,
    input  logic              data_addr_ok_i,
    input  logic              data_data_ok_i,
    input  logic [DATA_W-1:0] data_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] paddr;
    logic              fld_vld;
    logic              complete;
    logic              fast_hit;

    // kseg0/kseg1 fixed unmapping: strip the top three segment bits
    always_comb begin
        paddr = cpu_addr_i;
        if ((KSEG_MAP != 0) &&
            ((cpu_addr_i[ADDR_W-1 -: 3] == 3'b100) || (cpu_addr_i[ADDR_W-1 -: 3] == 3'b101))) begin
            paddr = {3'b000, cpu_addr_i[ADDR_W-4:0]};
        end
    end

    // Request fields are quiet only when idle with no access presented
    assign fld_vld      = (state_q != IDLE) | cpu_en_i;
    assign data_wr_o    = fld_vld & (|cpu_wen_i);
    assign data_addr_o  = fld_vld ? paddr : '0;
    assign data_wdata_o = fld_vld ? cpu_wdata_i : '0;
    assign data_size_o  = cpu_size_i;
    assign cpu_rdata_o  = fast_hit ? data_rdata_i : rdata_q;

    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        data_req_o  = 1'b0;
        cpu_stall_o = 1'b0;
        complete    = 1'b0;
        fast_hit    = 1'b0;
        case (state_q)
            IDLE: begin
                data_req_o  = cpu_en_i & ~cpu_flush_i;
                cpu_stall_o = cpu_en_i & ~cpu_flush_i;
                if (cpu_en_i && !cpu_flush_i) begin
                    if (data_addr_ok_i && data_data_ok_i) begin
                        rdata_d = data_rdata_i;
                        state_d = DONE;
                    end else if (data_addr_ok_i) begin
                        state_d = WAIT;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                data_req_o  = 1'b1;
                cpu_stall_o = cpu_en_i;
                if (data_addr_ok_i) begin
                    if (data_data_ok_i) begin
                        complete = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cpu_stall_o = cpu_en_i;
                if (data_data_ok_i) begin
                    complete = 1'b1;
                end
            end
            DONE: begin
                // Leave together with the pipeline advance, otherwise hold the result
                if (!cpu_longest_stall_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            rdata_d = data_rdata_i;
            state_d = DONE;
`ifdef SRAM_LIKE_FASTPATH_EN
            if (!cpu_longest_stall_i) begin
                fast_hit    = 1'b1;
                cpu_stall_o = 1'b0;
                state_d     = IDLE;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// Directed self-checking bench for data_sram_like_bridge (default build, KSEG_MAP=1).
module tb_data_sram_like_bridge;

    logic        clk;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_flush;
    logic        cpu_ls;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] S_IDLE = 32'd0;
    localparam logic [31:0] S_DONE = 32'd3;

    data_sram_like_bridge #(.ADDR_W(32), .DATA_W(32), .KSEG_MAP(1)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .cpu_en_i            (cpu_en),
        .cpu_wen_i           (cpu_wen),
        .cpu_size_i          (cpu_size),
        .cpu_addr_i          (cpu_addr),
        .cpu_wdata_i         (cpu_wdata),
        .cpu_flush_i         (cpu_flush),
        .cpu_longest_stall_i (cpu_ls),
        .cpu_rdata_o         (cpu_rdata),
        .cpu_stall_o         (cpu_stall),
        .data_req_o          (data_req),
        .data_wr_o           (data_wr),
        .data_size_o         (data_size),
        .data_addr_o         (data_addr),
        .data_wdata_o        (data_wdata),
        .data_addr_ok_i      (data_addr_ok),
        .data_data_ok_i      (data_data_ok),
        .data_rdata_i        (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        cpu_en       = 1'b0;
        cpu_wen      = 4'b0000;
        cpu_size     = 2'd2;
        cpu_addr     = 32'h0;
        cpu_wdata    = 32'h0;
        cpu_flush    = 1'b0;
        cpu_ls       = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
    endtask

    logic [31:0] vec [4];
    int          reqs;
    int          accepts;

    initial begin
        vec[0] = 32'h1111_0001;
        vec[1] = 32'h2222_0002;
        vec[2] = 32'h3333_0003;
        vec[3] = 32'h4444_0004;
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        #1;
        check("rst_state", 32'(dut.state_q), S_IDLE);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_req", 32'(data_req), 32'd0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_addr", data_addr, 32'h0);
        rst = 1'b0;
        nxt();

        // Read: addr_ok in cycle 0, data_ok in cycle 2
        cpu_en = 1'b1; cpu_addr = 32'hBFC0_1000; data_addr_ok = 1'b1;
        #1;
        check("rd_c0_req", 32'(data_req), 32'd1);
        check("rd_c0_addr", data_addr, 32'h1FC0_1000);
        check("rd_c0_wr", 32'(data_wr), 32'd0);
        check("rd_c0_stall", 32'(cpu_stall), 32'd1);
        nxt();
        data_addr_ok = 1'b0;
        #1;
        check("rd_c1_req", 32'(data_req), 32'd0);
        check("rd_c1_stall", 32'(cpu_stall), 32'd1);
        nxt();
        data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        #1;
        check("rd_c2_stall", 32'(cpu_stall), 32'd1);
        nxt();
        data_data_ok = 1'b0; data_rdata = 32'h0;
        #1;
        check("rd_c3_stall", 32'(cpu_stall), 32'd0);
        check("rd_c3_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("rd_c3_state", 32'(dut.state_q), S_DONE);
        nxt();
        cpu_en = 1'b0;
        #1;
        check("rd_c4_state", 32'(dut.state_q), S_IDLE);
        check("rd_c4_addr", data_addr, 32'h0);
        check("rd_c4_rdata", cpu_rdata, 32'hDEAD_BEEF);

        // Byte store, addr_ok after 3 wait cycles
        cpu_en = 1'b1; cpu_wen = 4'b0100; cpu_size = 2'd0;
        cpu_addr = 32'h8000_0012; cpu_wdata = 32'h00AB_0000;
        reqs = 0; accepts = 0;
        for (int c = 0; c < 4; c++) begin
            data_addr_ok = (c == 3);
            #1;
            if (data_req) reqs++;
            if (data_req && data_addr_ok) accepts++;
            check("st_wr", 32'(data_wr), 32'd1);
            check("st_size", 32'(data_size), 32'd0);
            check("st_addr", data_addr, 32'h0000_0012);
            check("st_stall", 32'(cpu_stall), 32'd1);
            nxt();
        end
        data_addr_ok = 1'b0;
        #1;
        if (data_req) reqs++;
        check("st_wait_wdata", data_wdata, 32'h00AB_0000);
        data_data_ok = 1'b1;
        nxt();
        data_data_ok = 1'b0;
        #1;
        if (data_req) reqs++;
        check("st_done_stall", 32'(cpu_stall), 32'd0);
        check("st_req_cycles", 32'(reqs), 32'd4);
        check("st_accepts", 32'(accepts), 32'd1);
        nxt();
        clear_inputs();
        nxt();

        // Read completes under an external freeze of 5 cycles
        cpu_en = 1'b1; cpu_addr = 32'h0000_2000;
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        #1;
        check("ls_c0_stall", 32'(cpu_stall), 32'd1);
        nxt();
        data_addr_ok = 1'b0; data_data_ok = 1'b0; cpu_ls = 1'b1;
        reqs = 0;
        for (int c = 0; c < 5; c++) begin
            data_rdata = 32'hBAD0_0000 + 32'(c);
            #1;
            if (data_req) reqs++;
            check("ls_hold_stall", 32'(cpu_stall), 32'd0);
            check("ls_hold_rdata", cpu_rdata, 32'h1234_5678);
            check("ls_hold_state", 32'(dut.state_q), S_DONE);
            nxt();
        end
        check("ls_no_req", 32'(reqs), 32'd0);
        cpu_ls = 1'b0;
        #1;
        check("ls_release_state", 32'(dut.state_q), S_DONE);
        nxt();
        cpu_en = 1'b0;
        #1;
        check("ls_back_idle", 32'(dut.state_q), S_IDLE);
        nxt();

        // Flush with a fresh access in IDLE: nothing issued
        cpu_en = 1'b1; cpu_flush = 1'b1; cpu_addr = 32'hA000_0004;
        #1;
        check("fl_idle_req", 32'(data_req), 32'd0);
        check("fl_idle_stall", 32'(cpu_stall), 32'd0);
        check("fl_idle_addr", data_addr, 32'h0000_0004);
        nxt();
        #1;
        check("fl_idle_state", 32'(dut.state_q), S_IDLE);
        // Flush raised during WAIT: transaction still completes
        cpu_flush = 1'b0; data_addr_ok = 1'b1;
        nxt();
        data_addr_ok = 1'b0; cpu_flush = 1'b1;
        #1;
        check("fl_wait_req", 32'(data_req), 32'd0);
        check("fl_wait_stall", 32'(cpu_stall), 32'd1);
        nxt();
        data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
        #1;
        check("fl_dok_stall", 32'(cpu_stall), 32'd1);
        nxt();
        data_data_ok = 1'b0;
        #1;
        check("fl_done_state", 32'(dut.state_q), S_DONE);
        check("fl_done_stall", 32'(cpu_stall), 32'd0);
        check("fl_done_req", 32'(data_req), 32'd0);
        nxt();
        #1;
        check("fl_after_req", 32'(data_req), 32'd0);
        check("fl_after_stall", 32'(cpu_stall), 32'd0);
        check("fl_after_state", 32'(dut.state_q), S_IDLE);
        nxt();
        clear_inputs();
        nxt();

        // Zero-wait slave: four back-to-back loads
        cpu_addr = 32'hC000_0100;
        for (int k = 0; k < 4; k++) begin
            cpu_en = 1'b1; data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = vec[k];
            #1;
            check("zw_req", 32'(data_req), 32'd1);
            check("zw_stall", 32'(cpu_stall), 32'd1);
            check("zw_addr", data_addr, 32'hC000_0100);
            nxt();
            data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
            #1;
            check("zw_done_stall", 32'(cpu_stall), 32'd0);
            check("zw_done_req", 32'(data_req), 32'd0);
            check("zw_rdata", cpu_rdata, vec[k]);
            nxt();
        end
        clear_inputs();
        nxt();

        // Asynchronous reset while in WAIT
        cpu_en = 1'b1; cpu_addr = 32'h0000_3000; data_addr_ok = 1'b1;
        nxt();
        data_addr_ok = 1'b0;
        #1;
        check("rw_pre_stall", 32'(cpu_stall), 32'd1);
        rst = 1'b1; cpu_en = 1'b0;
        #1;
        check("rw_state", 32'(dut.state_q), S_IDLE);
        check("rw_stall", 32'(cpu_stall), 32'd0);
        check("rw_req", 32'(data_req), 32'd0);
        check("rw_rdata", cpu_rdata, 32'h0);
        nxt();
        rst = 1'b0;
        nxt();
        #1;
        check("rw_post_state", 32'(dut.state_q), S_IDLE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
